// File: rtl/multicast_scheduler_if.sv
// Bus bundle shared by the multicast scheduler, the global-buffer streams and the MultiCasters.
// The scheduler takes the master side and drives the broadcast and accept signals.
interface multicast_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_MC     = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int ID_WIDTH   = 4
);
  logic [2:0]                 req_valid;
  logic [2:0]                 req_ready;
  logic [3*TAG_WIDTH-1:0]     req_tag;
  logic [DATA_WIDTH-1:0]      ifmap_data_in;
  logic [DATA_WIDTH-1:0]      fltr_data_in;
  logic [2*DATA_WIDTH-1:0]    psum_data_in;
  logic [2:0]                 CASTER_EN;
  logic [TAG_WIDTH-1:0]       TAG;
  logic [NUM_MC*ID_WIDTH-1:0] ID;
  logic [DATA_WIDTH-1:0]      ifmap_data_B2M;
  logic [DATA_WIDTH-1:0]      fltr_data_B2M;
  logic [2*DATA_WIDTH-1:0]    psum_data_B2M;
  logic [NUM_MC-1:0]          CASTER_READY;
  logic [NUM_MC-1:0]          CASTER_VALID;

  modport master (
    input  req_valid, req_tag, ifmap_data_in, fltr_data_in, psum_data_in,
           CASTER_READY, CASTER_VALID,
    output req_ready, CASTER_EN, TAG, ID, ifmap_data_B2M, fltr_data_B2M, psum_data_B2M
  );

  modport slave (
    output req_valid, req_tag, ifmap_data_in, fltr_data_in, psum_data_in,
           CASTER_READY, CASTER_VALID,
    input  req_ready, CASTER_EN, TAG, ID, ifmap_data_B2M, fltr_data_B2M, psum_data_B2M
  );
endinterface

// File: rtl/multicast_scheduler.sv
// Round-robin multicast scheduler: accepts one word from ifmap/filter/psum, waits for all
// MultiCasters to be ready, broadcasts it, and for psum also waits for all to report done.
module multicast_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_MC     = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int ID_WIDTH   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  multicast_scheduler_if.master     bus,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_MC)-1:0] cfg_idx,
  input  logic [ID_WIDTH-1:0]       cfg_id,
  output logic                      cfg_err,
  output logic                      busy,
  output logic                      stall,
  output logic [3*16-1:0]           cast_cnt
);
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, CAST, WAIT_VAL} state_t;

  state_t               state_q, state_d;
  logic [1:0]           last_grant_q;
  logic [1:0]           g_q;
  logic [1:0]           grant;
  logic [1:0]           cand;
  logic                 grant_vld;
  logic [WCW-1:0]       wait_cnt;
  logic [15:0]          cnt_q [3];
  logic [ID_WIDTH-1:0]  id_q  [NUM_MC];

  function automatic logic [1:0] rr_next(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    grant_vld     = 1'b0;
    grant         = 2'd0;
    cand          = rr_next(last_grant_q);
    bus.req_ready = '0;
    bus.CASTER_EN = '0;
    unique case (state_q)
      IDLE: begin
        if (!rst) begin
          for (int off = 0; off < 3; off++) begin
            if (!grant_vld && bus.req_valid[cand]) begin
              grant_vld = 1'b1;
              grant     = cand;
            end
            cand = rr_next(cand);
          end
          if (grant_vld) begin
            bus.req_ready = 3'b001 << grant;
            state_d       = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: if (&bus.CASTER_READY) state_d = CAST;
      CAST: begin
        bus.CASTER_EN = 3'b001 << g_q;
        state_d       = (g_q == 2'd2) ? WAIT_VAL : IDLE;
      end
      WAIT_VAL: if (&bus.CASTER_VALID) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q                <= 2'd0;
      last_grant_q       <= 2'd2;
      bus.TAG            <= '0;
      bus.ifmap_data_B2M <= '0;
      bus.fltr_data_B2M  <= '0;
      bus.psum_data_B2M  <= '0;
      wait_cnt           <= '0;
      cfg_err            <= 1'b0;
      for (int s = 0; s < 3; s++) cnt_q[s] <= '0;
      // NOTE: the ID file is small and its reset value is architecturally visible, so it is reset.
      for (int k = 0; k < NUM_MC; k++) id_q[k] <= '0;
    end else begin
      cfg_err <= 1'b0;
      if (grant_vld) begin
        g_q          <= grant;
        last_grant_q <= grant;
        case (grant)
          2'd0: begin
            bus.TAG            <= bus.req_tag[TAG_WIDTH-1:0];
            bus.ifmap_data_B2M <= bus.ifmap_data_in;
          end
          2'd1: begin
            bus.TAG           <= bus.req_tag[2*TAG_WIDTH-1:TAG_WIDTH];
            bus.fltr_data_B2M <= bus.fltr_data_in;
          end
          default: begin
            bus.TAG           <= bus.req_tag[3*TAG_WIDTH-1:2*TAG_WIDTH];
            bus.psum_data_B2M <= bus.psum_data_in;
          end
        endcase
      end
      // A grant wins over a config write; the error flag shows in the cycle after the drop.
      if (cfg_we) begin
        if (state_q == IDLE && !grant_vld) id_q[cfg_idx] <= cfg_id;
        else                               cfg_err       <= 1'b1;
      end
      if (state_q == WAIT_RDY) begin
        if (&bus.CASTER_READY)                wait_cnt <= '0;
        else if (wait_cnt != WCW'(TIMEOUT))   wait_cnt <= wait_cnt + 1'b1;
      end
      if (state_q == CAST) cnt_q[g_q] <= cnt_q[g_q] + 16'd1;
    end
  end

  always_comb begin
    bus.ID = '0;
    for (int k = 0; k < NUM_MC; k++) bus.ID[k*ID_WIDTH +: ID_WIDTH] = id_q[k];
  end

  assign cast_cnt = {cnt_q[2], cnt_q[1], cnt_q[0]};
  assign busy     = (state_q != IDLE);
  assign stall    = (wait_cnt >= WCW'(TIMEOUT));
endmodule

// File: tb/tb_multicast_scheduler.sv
// Self-checking bench for multicast_scheduler: directed vector table, corner-case sequences,
// then random traffic compared against a transaction-level reference model.
module tb_multicast_scheduler;
  localparam int DW = 16;
  localparam int NM = 4;
  localparam int TW = 4;
  localparam int IW = 4;
  localparam int TO = 64;

  logic           clk;
  logic           rst;
  logic           cfg_we;
  logic [1:0]     cfg_idx;
  logic [IW-1:0]  cfg_id;
  logic           cfg_err;
  logic           busy;
  logic           stall;
  logic [47:0]    cast_cnt;

  int checks = 0;
  int errors = 0;

  multicast_scheduler_if #(.DATA_WIDTH(DW), .NUM_MC(NM), .TAG_WIDTH(TW), .ID_WIDTH(IW)) bus ();

  multicast_scheduler #(
    .DATA_WIDTH(DW), .NUM_MC(NM), .TAG_WIDTH(TW), .ID_WIDTH(IW), .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_id   (cfg_id),
    .cfg_err  (cfg_err),
    .busy     (busy),
    .stall    (stall),
    .cast_cnt (cast_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [2:0]  rv;
    logic [3:0]  rdy;
    logic [3:0]  vld;
    logic        we;
    logic [1:0]  idx;
    logic [3:0]  id;
    logic [2:0]  e_rr;
    logic [2:0]  e_en;
    logic        e_busy;
    logic        e_err;
    logic [3:0]  e_tag;
    logic [15:0] e_id;
  } vec_t;

  vec_t vecs [19];

  // Reference model state (transaction view, not the scheduler's state encoding)
  bit          m_open, m_rdy_seen, m_cast_done, m_err;
  int          m_stream, m_waited, m_last;
  logic [3:0]  m_tag;
  logic [15:0] m_if, m_fl;
  logic [31:0] m_ps;
  logic [3:0]  m_id  [4];
  logic [15:0] m_cnt [3];
  bit          pend  [3];
  logic [3:0]  p_tag [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_open = 0; m_rdy_seen = 0; m_cast_done = 0; m_err = 0;
    m_stream = 0; m_waited = 0; m_last = 2;
    m_tag = '0; m_if = '0; m_fl = '0; m_ps = '0;
    for (int k = 0; k < 4; k++) m_id[k] = '0;
    for (int s = 0; s < 3; s++) m_cnt[s] = '0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model across the edge.
  task automatic model_cycle();
    int g;
    bit rej;
    logic [2:0] e_rr, e_en;
    g = -1;
    if (!rst && !m_open)
      for (int off = 1; off <= 3; off++)
        if (g < 0 && pend[(m_last + off) % 3]) g = (m_last + off) % 3;
    e_rr = (g >= 0) ? 3'(1 << g) : 3'b000;
    e_en = (m_open && m_rdy_seen && !m_cast_done) ? 3'(1 << m_stream) : 3'b000;
    check("rnd_req_ready", 64'(bus.req_ready), 64'(e_rr));
    check("rnd_caster_en", 64'(bus.CASTER_EN), 64'(e_en));
    check("rnd_busy",      64'(busy),          64'(m_open));
    check("rnd_stall",     64'(stall),         64'(m_open && !m_rdy_seen && m_waited >= TO));
    check("rnd_cfg_err",   64'(cfg_err),       64'(m_err));
    check("rnd_tag",       64'(bus.TAG),       64'(m_tag));
    check("rnd_data", {bus.ifmap_data_B2M, bus.fltr_data_B2M, bus.psum_data_B2M},
          {m_if, m_fl, m_ps});
    check("rnd_id",        64'(bus.ID),        64'({m_id[3], m_id[2], m_id[1], m_id[0]}));
    check("rnd_cast_cnt",  64'(cast_cnt),      64'({m_cnt[2], m_cnt[1], m_cnt[0]}));
    if (rst) begin
      model_reset();
    end else begin
      rej = cfg_we && (m_open || g >= 0);
      if (cfg_we && !rej) m_id[cfg_idx] = cfg_id;
      if (g >= 0) begin
        m_open = 1; m_stream = g; m_last = g;
        m_rdy_seen = 0; m_cast_done = 0; m_waited = 0;
        m_tag = p_tag[g];
        if (g == 0)      m_if = bus.ifmap_data_in;
        else if (g == 1) m_fl = bus.fltr_data_in;
        else             m_ps = bus.psum_data_in;
        pend[g] = 0;
      end else if (m_open && !m_rdy_seen) begin
        if (&bus.CASTER_READY) m_rdy_seen = 1;
        else if (m_waited < TO) m_waited++;
      end else if (m_open && !m_cast_done) begin
        m_cnt[m_stream] = m_cnt[m_stream] + 16'd1;
        m_cast_done = 1;
        if (m_stream != 2) m_open = 0;
      end else if (m_open && (&bus.CASTER_VALID)) begin
        m_open = 0;
      end
      m_err = rej;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_stall, busy_low;
    bit cast_seen;

    //            rst rv      rdy   vld   we idx id    e_rr    e_en    busy err tag e_id
    vecs[0]  = '{1'b1, 3'b000, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000};
    vecs[1]  = '{1'b0, 3'b001, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 3'b001, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000};
    vecs[2]  = '{1'b0, 3'b000, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b000, 1'b1, 1'b0, 4'h5, 16'h0000};
    vecs[3]  = '{1'b0, 3'b000, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b001, 1'b1, 1'b0, 4'h5, 16'h0000};
    vecs[4]  = '{1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 2'd2, 4'hA, 3'b000, 3'b000, 1'b0, 1'b0, 4'h5, 16'h0000};
    vecs[5]  = '{1'b0, 3'b010, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 3'b010, 3'b000, 1'b0, 1'b0, 4'h5, 16'h0A00};
    vecs[6]  = '{1'b0, 3'b000, 4'h7, 4'h0, 1'b1, 2'd1, 4'h3, 3'b000, 3'b000, 1'b1, 1'b0, 4'h6, 16'h0A00};
    vecs[7]  = '{1'b0, 3'b000, 4'h7, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b000, 1'b1, 1'b1, 4'h6, 16'h0A00};
    vecs[8]  = '{1'b0, 3'b000, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b000, 1'b1, 1'b0, 4'h6, 16'h0A00};
    vecs[9]  = '{1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b010, 1'b1, 1'b0, 4'h6, 16'h0A00};
    vecs[10] = '{1'b0, 3'b111, 4'h0, 4'h0, 1'b1, 2'd0, 4'hF, 3'b100, 3'b000, 1'b0, 1'b0, 4'h6, 16'h0A00};
    vecs[11] = '{1'b0, 3'b111, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b000, 1'b1, 1'b1, 4'h7, 16'h0A00};
    vecs[12] = '{1'b0, 3'b000, 4'h0, 4'hF, 1'b0, 2'd0, 4'h0, 3'b000, 3'b100, 1'b1, 1'b0, 4'h7, 16'h0A00};
    vecs[13] = '{1'b0, 3'b000, 4'h0, 4'h7, 1'b0, 2'd0, 4'h0, 3'b000, 3'b000, 1'b1, 1'b0, 4'h7, 16'h0A00};
    vecs[14] = '{1'b0, 3'b000, 4'h0, 4'hF, 1'b0, 2'd0, 4'h0, 3'b000, 3'b000, 1'b1, 1'b0, 4'h7, 16'h0A00};
    vecs[15] = '{1'b0, 3'b111, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 3'b001, 3'b000, 1'b0, 1'b0, 4'h7, 16'h0A00};
    vecs[16] = '{1'b0, 3'b000, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b000, 1'b1, 1'b0, 4'h5, 16'h0A00};
    vecs[17] = '{1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b001, 1'b1, 1'b0, 4'h5, 16'h0A00};
    vecs[18] = '{1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 3'b000, 3'b000, 1'b0, 1'b0, 4'h5, 16'h0A00};

    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_id = '0;
    bus.req_valid = '0; bus.req_tag = {4'h7, 4'h6, 4'h5};
    bus.ifmap_data_in = 16'h1234; bus.fltr_data_in = 16'h5678; bus.psum_data_in = 32'h0BADF00D;
    bus.CASTER_READY = '0; bus.CASTER_VALID = '0;
    tick();

    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst; bus.req_valid = vecs[i].rv;
      bus.CASTER_READY = vecs[i].rdy; bus.CASTER_VALID = vecs[i].vld;
      cfg_we = vecs[i].we; cfg_idx = vecs[i].idx; cfg_id = vecs[i].id;
      @(negedge clk);
      check($sformatf("vec%0d_req_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_rr));
      check($sformatf("vec%0d_caster_en", i), 64'(bus.CASTER_EN), 64'(vecs[i].e_en));
      check($sformatf("vec%0d_busy", i),      64'(busy),          64'(vecs[i].e_busy));
      check($sformatf("vec%0d_cfg_err", i),   64'(cfg_err),       64'(vecs[i].e_err));
      check($sformatf("vec%0d_tag", i),       64'(bus.TAG),       64'(vecs[i].e_tag));
      check($sformatf("vec%0d_id", i),        64'(bus.ID),        64'(vecs[i].e_id));
      if (i == 0) begin
        check("reset_data", {bus.ifmap_data_B2M, bus.fltr_data_B2M, bus.psum_data_B2M}, 64'h0);
        check("reset_cast_cnt", 64'(cast_cnt), 64'h0);
        check("reset_stall", 64'(stall), 64'h0);
      end
      tick();
    end
    check("table_cast_cnt", 64'(cast_cnt), 64'h0001_0001_0002);
    check("table_data", {bus.ifmap_data_B2M, bus.fltr_data_B2M, bus.psum_data_B2M},
          64'h1234_5678_0BAD_F00D);

    // Ready gating: one MultiCaster stays not-ready well past the timeout
    cfg_we = 1'b0; bus.req_valid = 3'b010; bus.CASTER_READY = 4'h7; bus.CASTER_VALID = '0;
    @(negedge clk);
    check("stall_accept", 64'(bus.req_ready), 64'(3'b010));
    tick();
    bus.req_valid = '0;
    first_stall = -1; cast_seen = 0;
    for (int j = 0; j < 70; j++) begin
      @(negedge clk);
      if (stall && first_stall < 0) first_stall = j;
      if (bus.CASTER_EN != 3'b000) cast_seen = 1;
      tick();
    end
    check("stall_first_cycle", 64'(first_stall), 64'(64));
    check("stall_no_cast", 64'(cast_seen), 64'(0));
    bus.CASTER_READY = 4'hF;
    @(negedge clk);
    check("stall_held_at_ready", 64'(stall), 64'(1));
    tick();
    @(negedge clk);
    check("stall_cast_en", 64'(bus.CASTER_EN), 64'(3'b010));
    check("stall_clear_in_cast", 64'(stall), 64'(0));
    tick();

    // psum completion: MultiCasters report done only after five cycles
    bus.req_valid = 3'b100; bus.psum_data_in = 32'hDEADBEEF;
    @(negedge clk);
    check("psum_accept", 64'(bus.req_ready), 64'(3'b100));
    tick();
    bus.req_valid = '0;
    tick();
    @(negedge clk);
    check("psum_cast_en", 64'(bus.CASTER_EN), 64'(3'b100));
    check("psum_data", 64'(bus.psum_data_B2M), 64'h0000_0000_DEAD_BEEF);
    tick();
    busy_low = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      tick();
    end
    check("psum_busy_through_wait", 64'(busy_low), 64'(0));
    bus.CASTER_VALID = 4'hF;
    @(negedge clk);
    check("psum_busy_last", 64'(busy), 64'(1));
    tick();
    bus.CASTER_VALID = '0;
    @(negedge clk);
    check("psum_busy_drop", 64'(busy), 64'(0));
    check("psum_cast_cnt", 64'(cast_cnt), 64'h0002_0002_0002);
    tick();

    // Reset while a psum waits for completion
    bus.req_valid = 3'b100; bus.psum_data_in = 32'h13572468;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_before", 64'(busy), 64'(1));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_caster_en", 64'(bus.CASTER_EN), 64'(0));
    check("rst_tag", 64'(bus.TAG), 64'(0));
    check("rst_data", {bus.ifmap_data_B2M, bus.fltr_data_B2M, bus.psum_data_B2M}, 64'h0);
    check("rst_id", 64'(bus.ID), 64'(0));
    check("rst_cast_cnt", 64'(cast_cnt), 64'(0));
    check("rst_stall_err", 64'({stall, cfg_err}), 64'(0));
    tick();
    @(negedge clk);
    check("rst_no_rerequest", 64'({bus.req_ready, busy}), 64'(0));
    tick();

    // Random traffic against the reference model
    model_reset();
    for (int s = 0; s < 3; s++) begin pend[s] = 0; p_tag[s] = '0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int s = 0; s < 3; s++) begin
        if (!pend[s] && $urandom_range(0, 2) == 0) begin
          pend[s] = 1;
          p_tag[s] = 4'($urandom);
          if (s == 0)      bus.ifmap_data_in = 16'($urandom);
          else if (s == 1) bus.fltr_data_in  = 16'($urandom);
          else             bus.psum_data_in  = $urandom;
        end
      end
      bus.req_valid    = {pend[2], pend[1], pend[0]};
      bus.req_tag      = {p_tag[2], p_tag[1], p_tag[0]};
      bus.CASTER_READY = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      bus.CASTER_VALID = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      cfg_we  = ($urandom_range(0, 4) == 0);
      cfg_idx = 2'($urandom);
      cfg_id  = 4'($urandom);
      @(negedge clk);
      model_cycle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
